instr_decode_stage: RTL and testbench
=====================================

// Module: instr_decode_stage
// PURPOSE
//  Registered decode stage directly upstream of the immediate sign-extender.
//  - Accepts 32-bit instruction words from fetch over a valid/ready handshake and buffers them in a 2-entry skid buffer.
//  - Splits each word into register/immediate fields and classifies it.
//  - Presents the raw imm16 plus an extend-mode flag; the sign-extender and register file consume these downstream.
//  - Sustains 1 instr/cycle with full backpressure.
// PARAMETERS
//  IW     32  instruction width
//  IMM_W  16  immediate field width (matches sign-extender input width)
//  OPC_W  6   opcode field width
//  REG_W  5   register specifier width
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  rst         in   1      synchronous, active-high reset
//  flush       in   1      discard all buffered instructions (branch redirect)
//  in_valid    in   1      fetch presents instr
//  in_ready    out  1      stage can accept instr this cycle
//  instr       in   IW     instruction word
//  out_valid   out  1      decoded fields valid
//  out_ready   in   1      downstream consumes this cycle
//  opcode      out  OPC_W  instr[31:26]
//  rs          out  REG_W  instr[25:21]
//  rt          out  REG_W  instr[20:16]
//  rd          out  REG_W  instr[15:11]
//  funct       out  6      instr[5:0]
//  imm16       out  IMM_W  instr[15:0], raw, to sign-extender din
//  imm_signed  out  1      1 = sign-extend imm16, 0 = zero-extend
//  iclass      out  2      0 R-type, 1 I-type, 2 J-type, 3 illegal
//  illegal     out  1      iclass==3 && out_valid
// BEHAVIOUR
//  - Handshakes: accept when in_valid&&in_ready; emit when out_valid&&out_ready. Inputs are sampled only on accept.
//    Output fields are held stable while out_valid && !out_ready.
//  - Occupancy FSM: EMPTY -> ONE on accept without emit.
//    ONE -> TWO on accept && !emit. ONE -> EMPTY on emit && !accept. ONE stays ONE on accept && emit.
//    TWO -> ONE on emit. No accept is possible in TWO.
//  - in_ready is registered: 1 in EMPTY/ONE, 0 in TWO and while rst is high.
//  - out_valid = (state != EMPTY).
//  - Latency: an instr accepted in cycle N has out_valid=1 in cycle N+1 when the stage was EMPTY.
//  - Order is strictly FIFO. The head entry drives the outputs; the skid entry moves to head on emit.
//  - Field extraction and classification are computed on the head entry (combinational from registered data).
//  - iclass encoding:
//    - opcode 0x00 -> R-type.
//    - 0x02, 0x03 -> J-type.
//    - 0x04, 0x05, 0x08, 0x09, 0x0A, 0x0C, 0x0D, 0x0E, 0x0F, 0x23, 0x2B -> I-type.
//    - Any other opcode -> illegal. Illegal words still flow through; they are never dropped.
//  - imm_signed = 0 for opcodes 0x0C/0x0D/0x0E (ANDI/ORI/XORI); 1 for all other opcodes.
//  - Reset: state=EMPTY, out_valid=0, in_ready=0, all field outputs 0, iclass=0, illegal=0.
//    in_ready rises the first cycle after rst deasserts.
//  - flush: next state is EMPTY and both entries are invalidated. It has priority over a same-cycle accept, which is dropped.
//    An emit in the flush cycle still counts as consumed.
//  - Reset asserted mid-transfer: contents are discarded exactly as with flush, and the outputs take their reset values.
//  - Simultaneous accept and emit in ONE: head is replaced by the new word and no bubble is inserted.
// STRUCTURE
//  - Package decode_pkg holds:
//    - the opcode localparams (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW, ...);
//    - the iclass encodings;
//    - the field bit positions.
//  - Sub-module skid_buffer2 (#(W)): 2-entry valid/ready buffer with flush. The decode logic is a combinational wrapper around its head output.
// TESTING
//  1. Reset: hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, imm16=0. The cycle after release, in_ready=1.
//  2. Single instr 0x2128FFFC (ADDI): next cycle opcode=0x08, rs=9, rt=8, imm16=0xFFFC, imm_signed=1, iclass=1.
//  3. ORI 0x3508F000 -> imm_signed=0, iclass=1. Word 0xFC000000 -> iclass=3, illegal=1, still emitted.
//  4. Backpressure: stream 4 words with out_ready=0 -> in_ready drops after 2 accepts.
//     Raise out_ready -> all 4 words emerge in order with no loss or duplication.
//  5. Throughput: in_valid=1, out_ready=1 for 10 cycles -> 10 emits in 10 consecutive cycles after first.
//  6. Flush while TWO with same-cycle in_valid=1 -> next cycle out_valid=0, state EMPTY; the flushed-cycle word never appears.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, instruction classes, field positions,
// and the skid-buffer occupancy states.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int OPC_LSB   = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_LSB = 0;
    localparam int FUNCT_W   = 6;
    localparam int IMM_LSB   = 0;

    typedef enum logic [1:0] {
        ICLASS_R       = 2'd0,
        ICLASS_I       = 2'd1,
        ICLASS_J       = 2'd2,
        ICLASS_ILLEGAL = 2'd3
    } iclass_t;

    typedef enum logic [1:0] {
        SB_EMPTY = 2'd0,
        SB_ONE   = 2'd1,
        SB_TWO   = 2'd2
    } sb_state_t;

    function automatic iclass_t classify(input logic [5:0] op);
        iclass_t cls;
        case (op)
            OP_RTYPE:     cls = ICLASS_R;
            OP_J, OP_JAL: cls = ICLASS_J;
            OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
            OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW:
                          cls = ICLASS_I;
            default:      cls = ICLASS_ILLEGAL;
        endcase
        return cls;
    endfunction

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic zero_extends(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/instr_decode_stage_skid_buffer2.sv
// Two-entry valid/ready skid buffer with flush; head entry always drives dout.
module skid_buffer2
    import decode_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] din,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] dout
);

    sb_state_t    state;
    logic [W-1:0] headEntry;
    logic [W-1:0] skidEntry;
    logic         accept;
    logic         emit;

    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;
    assign out_valid = (state != SB_EMPTY);
    assign dout      = headEntry;

    // Occupancy FSM; in_ready is registered as "next state is not full".
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state     <= SB_EMPTY;
            headEntry <= '0;
            skidEntry <= '0;
            in_ready  <= !rst;
        end else begin
            in_ready <= 1'b1;
            case (state)
                SB_EMPTY: begin
                    if (accept) begin
                        headEntry <= din;
                        state     <= SB_ONE;
                    end
                end
                SB_ONE: begin
                    if (accept && emit) begin
                        headEntry <= din;
                    end else if (accept) begin
                        skidEntry <= din;
                        state     <= SB_TWO;
                        in_ready  <= 1'b0;
                    end else if (emit) begin
                        state <= SB_EMPTY;
                    end
                end
                SB_TWO: begin
                    if (emit) begin
                        headEntry <= skidEntry;
                        state     <= SB_ONE;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    state <= SB_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: buffers fetched words and splits the head entry
// into register/immediate fields plus a class and extend-mode flag.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int IW    = 32,
    parameter int IMM_W = 16,
    parameter int OPC_W = 6,
    parameter int REG_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IW-1:0]      instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   opcode,
    output logic [REG_W-1:0]   rs,
    output logic [REG_W-1:0]   rt,
    output logic [REG_W-1:0]   rd,
    output logic [FUNCT_W-1:0] funct,
    output logic [IMM_W-1:0]   imm16,
    output logic               imm_signed,
    output logic [1:0]         iclass,
    output logic               illegal
);

    logic [IW-1:0] headWord;
    iclass_t       headClass;

    skid_buffer2 #(
        .W(IW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (headWord)
    );

    assign opcode = headWord[OPC_LSB +: OPC_W];
    assign rs     = headWord[RS_LSB +: REG_W];
    assign rt     = headWord[RT_LSB +: REG_W];
    assign rd     = headWord[RD_LSB +: REG_W];
    assign funct  = headWord[FUNCT_LSB +: FUNCT_W];
    assign imm16  = headWord[IMM_LSB +: IMM_W];

    // Class and extend mode are only meaningful while a word is presented.
    assign headClass  = classify(opcode);
    assign iclass     = headClass;
    assign illegal    = out_valid && (headClass == ICLASS_ILLEGAL);
    assign imm_signed = out_valid && !zero_extends(opcode);

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode vector table plus handshake,
// backpressure, throughput, flush and reset sequences against a FIFO model.
module tb_instr_decode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [31:0] instr;
    logic        outValid;
    logic        outReady;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic        immSigned;
    logic [1:0]  iclass;
    logic        illegal;

    int checks   = 0;
    int failures = 0;
    int emitCount = 0;
    bit lastEmit  = 0;
    logic [31:0] expQ[$];

    typedef struct {
        logic [31:0] word;
        logic [5:0]  opc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic        immSigned;
        logic [1:0]  cls;
        logic        illegal;
    } vec_t;

    vec_t vecs[13];

    instr_decode_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .instr      (instr),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .funct      (funct),
        .imm16      (imm16),
        .imm_signed (immSigned),
        .iclass     (iclass),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] word, input logic valid, input logic ready);
        instr    = word;
        inValid  = valid;
        outReady = ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with FIFO-model bookkeeping, then occupancy checks.
    task automatic runCycle(input string tag);
        bit acc;
        bit em;
        acc = inValid && inReady && !flush && !rst;
        em  = outValid && outReady;
        lastEmit = em;
        if (em) begin
            emitCount++;
            if (expQ.size() == 0) begin
                checkOutput({tag, "_spurious_emit"}, {opcode, rs, rt, imm16}, 32'hXXXXXXXX);
            end else begin
                checkOutput({tag, "_emit_word"}, {opcode, rs, rt, imm16}, expQ.pop_front());
            end
        end
        if (flush) expQ.delete();
        if (acc) expQ.push_back(instr);
        tick();
        checkOutput({tag, "_out_valid"}, {31'd0, outValid}, {31'd0, expQ.size() > 0});
        checkOutput({tag, "_in_ready"}, {31'd0, inReady}, {31'd0, expQ.size() < 2});
    endtask

    initial begin
        vecs[0]  = '{32'h2128FFFC, 6'h08, 5'd9, 5'd8, 5'd31, 6'h3C, 16'hFFFC, 1'b1, 2'd1, 1'b0};
        vecs[1]  = '{32'h3508F000, 6'h0D, 5'd8, 5'd8, 5'd30, 6'h00, 16'hF000, 1'b0, 2'd1, 1'b0};
        vecs[2]  = '{32'hFC000000, 6'h3F, 5'd0, 5'd0, 5'd0,  6'h00, 16'h0000, 1'b1, 2'd3, 1'b1};
        vecs[3]  = '{32'h00221820, 6'h00, 5'd1, 5'd2, 5'd3,  6'h20, 16'h1820, 1'b1, 2'd0, 1'b0};
        vecs[4]  = '{32'h08100004, 6'h02, 5'd0, 5'd16, 5'd0, 6'h04, 16'h0004, 1'b1, 2'd2, 1'b0};
        vecs[5]  = '{32'h304200FF, 6'h0C, 5'd2, 5'd2, 5'd0,  6'h3F, 16'h00FF, 1'b0, 2'd1, 1'b0};
        vecs[6]  = '{32'h38628001, 6'h0E, 5'd3, 5'd2, 5'd16, 6'h01, 16'h8001, 1'b0, 2'd1, 1'b0};
        vecs[7]  = '{32'h8C850010, 6'h23, 5'd4, 5'd5, 5'd0,  6'h10, 16'h0010, 1'b1, 2'd1, 1'b0};
        vecs[8]  = '{32'hAC85FFF0, 6'h2B, 5'd4, 5'd5, 5'd31, 6'h30, 16'hFFF0, 1'b1, 2'd1, 1'b0};
        vecs[9]  = '{32'h3C011234, 6'h0F, 5'd0, 5'd1, 5'd2,  6'h34, 16'h1234, 1'b1, 2'd1, 1'b0};
        vecs[10] = '{32'h1C000000, 6'h07, 5'd0, 5'd0, 5'd0,  6'h00, 16'h0000, 1'b1, 2'd3, 1'b1};
        vecs[11] = '{32'h0C000001, 6'h03, 5'd0, 5'd0, 5'd0,  6'h01, 16'h0001, 1'b1, 2'd2, 1'b0};
        vecs[12] = '{32'h1000FFFF, 6'h04, 5'd0, 5'd0, 5'd31, 6'h3F, 16'hFFFF, 1'b1, 2'd1, 1'b0};

        // Reset held three cycles with fetch already offering a word.
        rst = 1'b1;
        flush = 1'b0;
        applyStimulus(32'h2128FFFC, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_in_ready", {31'd0, inReady}, 32'd0);
            checkOutput("rst_out_valid", {31'd0, outValid}, 32'd0);
            checkOutput("rst_imm16", {16'd0, imm16}, 32'd0);
            checkOutput("rst_iclass", {30'd0, iclass}, 32'd0);
            checkOutput("rst_illegal", {31'd0, illegal}, 32'd0);
        end
        rst = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("post_rst_in_ready", {31'd0, inReady}, 32'd1);
        checkOutput("post_rst_out_valid", {31'd0, outValid}, 32'd0);

        // Decode table: accept from EMPTY, check next cycle, hold, then drain.
        for (int v = 0; v < 13; v++) begin
            applyStimulus(vecs[v].word, 1'b1, 1'b0);
            tick();
            applyStimulus(32'h0, 1'b0, 1'b0);
            checkOutput("vec_out_valid", {31'd0, outValid}, 32'd1);
            checkOutput("vec_opcode", {26'd0, opcode}, {26'd0, vecs[v].opc});
            checkOutput("vec_rs", {27'd0, rs}, {27'd0, vecs[v].rs});
            checkOutput("vec_rt", {27'd0, rt}, {27'd0, vecs[v].rt});
            checkOutput("vec_rd", {27'd0, rd}, {27'd0, vecs[v].rd});
            checkOutput("vec_funct", {26'd0, funct}, {26'd0, vecs[v].funct});
            checkOutput("vec_imm16", {16'd0, imm16}, {16'd0, vecs[v].imm});
            checkOutput("vec_imm_signed", {31'd0, immSigned}, {31'd0, vecs[v].immSigned});
            checkOutput("vec_iclass", {30'd0, iclass}, {30'd0, vecs[v].cls});
            checkOutput("vec_illegal", {31'd0, illegal}, {31'd0, vecs[v].illegal});
            tick();
            checkOutput("vec_hold_word", {opcode, rs, rt, imm16}, vecs[v].word);
            checkOutput("vec_hold_valid", {31'd0, outValid}, 32'd1);
            applyStimulus(32'h0, 1'b0, 1'b1);
            tick();
            applyStimulus(32'h0, 1'b0, 1'b0);
            checkOutput("vec_drained", {31'd0, outValid}, 32'd0);
        end

        // Backpressure: offer four words with out_ready low, then drain.
        begin
            logic [31:0] words[4];
            int idx;
            words[0] = 32'h20010001;
            words[1] = 32'h20020002;
            words[2] = 32'h20030003;
            words[3] = 32'h20040004;
            idx = 0;
            for (int c = 0; c < 4; c++) begin
                applyStimulus(words[idx], 1'b1, 1'b0);
                if (inReady) idx++;
                runCycle("bp_fill");
            end
            checkOutput("bp_accepted", idx, 32'd2);
            checkOutput("bp_in_ready_low", {31'd0, inReady}, 32'd0);
            for (int c = 0; c < 12 && expQ.size() + (4 - idx) > 0; c++) begin
                applyStimulus(words[idx < 4 ? idx : 3], idx < 4, 1'b1);
                if (idx < 4 && inReady) idx++;
                runCycle("bp_drain");
            end
            checkOutput("bp_all_sent", idx, 32'd4);
            checkOutput("bp_queue_empty", expQ.size(), 32'd0);
            checkOutput("bp_emit_total", emitCount, 32'd4);
        end

        // Throughput: ten back-to-back words with downstream always ready.
        emitCount = 0;
        for (int c = 0; c < 11; c++) begin
            applyStimulus(32'h24000000 + c, c < 10, 1'b1);
            runCycle("tp");
            if (c > 0) checkOutput("tp_emit_every_cycle", {31'd0, lastEmit}, 32'd1);
        end
        applyStimulus(32'h0, 1'b0, 1'b0);
        checkOutput("tp_emit_total", emitCount, 32'd10);

        // Flush while full, with fetch offering a word in the same cycle.
        applyStimulus(32'h20110011, 1'b1, 1'b0);
        runCycle("fl_fill");
        applyStimulus(32'h20120012, 1'b1, 1'b0);
        runCycle("fl_fill");
        flush = 1'b1;
        applyStimulus(32'hDEADBEEF, 1'b1, 1'b0);
        runCycle("fl_two");
        flush = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b0);
        checkOutput("fl_two_out_valid", {31'd0, outValid}, 32'd0);

        // Flush in ONE: same-cycle accept dropped, same-cycle emit consumed.
        applyStimulus(32'h20130013, 1'b1, 1'b0);
        runCycle("fl_one_fill");
        flush = 1'b1;
        applyStimulus(32'hBADC0DE0, 1'b1, 1'b1);
        runCycle("fl_one");
        flush = 1'b0;
        applyStimulus(32'h20140014, 1'b1, 1'b1);
        runCycle("fl_after");
        applyStimulus(32'h0, 1'b0, 1'b1);
        runCycle("fl_after");
        checkOutput("fl_after_word_seen", emitCount, 32'd12);

        // Reset asserted while full discards contents like a flush.
        applyStimulus(32'h20150015, 1'b1, 1'b0);
        runCycle("rm_fill");
        applyStimulus(32'h20160016, 1'b1, 1'b0);
        runCycle("rm_fill");
        rst = 1'b1;
        applyStimulus(32'h20170017, 1'b1, 1'b1);
        tick();
        expQ.delete();
        checkOutput("rm_out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("rm_in_ready", {31'd0, inReady}, 32'd0);
        checkOutput("rm_imm16", {16'd0, imm16}, 32'd0);
        checkOutput("rm_opcode", {26'd0, opcode}, 32'd0);
        rst = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("rm_release_in_ready", {31'd0, inReady}, 32'd1);
        checkOutput("rm_release_out_valid", {31'd0, outValid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
